// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control unit.
// Walks each instruction through fetch, decode, execute, memory and writeback,
// drives the datapath mux selects and enables, stalls on mem_ready and
// counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             mem_ready,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    output logic [2:0]       ImmSrc,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic             RegWrite,
    output logic             illegal,
    output logic [CNT_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_OP    = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI,
        ALUWB, BRANCH, JAL, JALR1, JALR2, LUI, AUIPC, TRAP
    } state_t;

    // Per-state control word. PCWrite/IRWrite have three sources: always,
    // qualified by mem_ready (fetch), or qualified by the branch outcome.
    typedef struct packed {
        logic       pcw;
        logic       pcw_rdy;
        logic       pcw_tkn;
        logic       irw_rdy;
        logic       adr;
        logic       mw;
        logic [1:0] rs;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       rw;
    } ctrl_t;

    state_t            state_q, state_d;
    ctrl_t             ctrl_q;
    logic              illegal_q;
    logic [CNT_W-1:0]  instret_q;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic              taken;
    logic              retire;
    logic              unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31:15], instr[11:7]};

    // Control word for a state; registered against the next state so that the
    // outputs come straight from flops while in that state.
    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.pcw_rdy = 1'b1; c.irw_rdy = 1'b1;
                c.srca = 2'b00; c.srcb = 2'b10; c.aluop = 2'b00; c.rs = 2'b10;
            end
            DECODE:   begin c.srca = 2'b01; c.srcb = 2'b01; end
            MEMADR:   begin c.srca = 2'b10; c.srcb = 2'b01; end
            MEMREAD:  begin c.adr = 1'b1; c.rs = 2'b00; end
            MEMWB:    begin c.rs = 2'b01; c.rw = 1'b1; end
            MEMWRITE: begin c.adr = 1'b1; c.mw = 1'b1; c.rs = 2'b00; end
            EXECUTER: begin c.srca = 2'b10; c.srcb = 2'b00; c.aluop = 2'b10; end
            EXECUTEI: begin c.srca = 2'b10; c.srcb = 2'b01; c.aluop = 2'b10; end
            ALUWB:    begin c.rs = 2'b00; c.rw = 1'b1; end
            BRANCH: begin
                c.srca = 2'b10; c.srcb = 2'b00; c.aluop = 2'b01; c.pcw_tkn = 1'b1;
            end
            JAL:      begin c.srca = 2'b01; c.srcb = 2'b10; c.pcw = 1'b1; end
            JALR1:    begin c.srca = 2'b10; c.srcb = 2'b01; c.rs = 2'b10; c.pcw = 1'b1; end
            JALR2:    begin c.srca = 2'b01; c.srcb = 2'b10; end
            LUI:      begin c.srca = 2'b11; c.srcb = 2'b01; end
            AUIPC:    begin c.srca = 2'b01; c.srcb = 2'b01; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    // Immediate format follows the opcode in every state.
    always_comb begin
        ImmSrc = 3'b000;
        case (opcode)
            OP_STORE:         ImmSrc = 3'b001;
            OP_BR:            ImmSrc = 3'b010;
            OP_LUI, OP_AUIPC: ImmSrc = 3'b011;
            OP_JAL:           ImmSrc = 3'b100;
            default:          ImmSrc = 3'b000;
        endcase
    end

    // Branch outcome from funct3 and the ALU flags.
    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = !zero;
            3'b100:  taken = lt;
            3'b101:  taken = !lt;
            3'b110:  taken = ltu;
            3'b111:  taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    // Next-state sequencing; memory states hold until mem_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: if (mem_ready) state_d = DECODE;
            DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_OP:             state_d = EXECUTER;
                    OP_IMM:            state_d = EXECUTEI;
                    // funct3 010/011 are unassigned branch encodings
                    OP_BR:             state_d = (funct3[2:1] == 2'b01) ? TRAP : BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR1;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR:   state_d = (opcode == OP_STORE) ? MEMWRITE : MEMREAD;
            MEMREAD:  if (mem_ready) state_d = MEMWB;
            MEMWB:    state_d = FETCH;
            MEMWRITE: if (mem_ready) state_d = FETCH;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            JALR1:    state_d = JALR2;
            JALR2:    state_d = ALUWB;
            LUI:      state_d = ALUWB;
            AUIPC:    state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = TRAP;
        endcase
    end

    // An instruction retires on the edge that leaves its last state.
    assign retire = (state_q == MEMWB) || (state_q == ALUWB) || (state_q == BRANCH) ||
                    ((state_q == MEMWRITE) && mem_ready);

    // State, registered control word, sticky illegal flag and retire counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            ctrl_q    <= ctrl_of(FETCH);
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_of(state_d);
            if (state_d == TRAP) illegal_q <= 1'b1;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Enables are suppressed while reset is held so nothing is written mid-reset.
    assign PCWrite   = !rst && (ctrl_q.pcw || (ctrl_q.pcw_rdy && mem_ready) ||
                                (ctrl_q.pcw_tkn && taken));
    assign IRWrite   = !rst && ctrl_q.irw_rdy && mem_ready;
    assign MemWrite  = !rst && ctrl_q.mw;
    assign RegWrite  = !rst && ctrl_q.rw;
    assign AdrSrc    = ctrl_q.adr;
    assign ResultSrc = ctrl_q.rs;
    assign ALUSrcA   = ctrl_q.srca;
    assign ALUSrcB   = ctrl_q.srcb;
    assign ALUOp     = ctrl_q.aluop;
    assign illegal   = illegal_q;
    assign instret   = instret_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
FSM control unit for the multicycle RV32I datapath. Sequences fetch, decode, execute, memory and writeback. Drives ImmSrc to the immediate generator and all datapath mux and enable controls. Stalls on a memory ready handshake and counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter instret

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
instr  in  32  instruction register contents (valid from DECODE onward)
mem_ready  in  1  memory handshake; access completes in a cycle where it is 1
zero  in  1  ALU result == 0
lt  in  1  ALU signed less-than
ltu  in  1  ALU unsigned less-than
ImmSrc  out  3  000 I, 001 S, 010 B, 011 U, 100 J
PCWrite  out  1  PC register enable
AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
MemWrite  out  1  data memory write strobe
IRWrite  out  1  instruction register and OldPC enable
ResultSrc  out  2  00 ALUOut, 01 memory data, 10 ALUResult
ALUSrcA  out  2  00 PC, 01 OldPC, 10 rs1 reg, 11 zero
ALUSrcB  out  2  00 rs2 reg, 01 imm, 10 constant 4
ALUOp  out  2  00 add, 01 compare/sub, 10 funct-decoded
RegWrite  out  1  register file write enable
illegal  out  1  sticky illegal-instruction flag
instret  out  CNT_W  retired instruction count

Behaviour:
- Reset (rst=1 at a clock edge):
  - state becomes FETCH; illegal clears to 0; instret clears to 0.
  - While rst=1, PCWrite, MemWrite, IRWrite and RegWrite are forced to 0.
- ImmSrc is combinational from opcode instr[6:0] in every state:
  - 0000011 and 0010011 give 000; 1100111 gives 000.
  - 0100011 gives 001; 1100011 gives 010.
  - 0110111 and 0010111 give 011; 1101111 gives 100.
  - Any other opcode gives 000.
- Every control output not listed for a state is 0.
- State outputs and next state:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite equal mem_ready. Goes to DECODE if mem_ready, else holds.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (ALUOut = branch/JAL target).
    - Load or store goes to MEMADR; OP goes to EXECUTER; OP-IMM goes to EXECUTEI.
    - BRANCH opcode goes to BRANCH; JAL to JAL; JALR to JALR1; LUI to LUI; AUIPC to AUIPC.
    - Any other opcode goes to TRAP.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Load goes to MEMREAD; store goes to MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Goes to MEMWB on mem_ready, else holds.
  - MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
  - MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held asserted while stalled. Goes to FETCH on mem_ready, else holds.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Goes to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
  - BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=taken. Goes to FETCH.
    - funct3 000 beq: taken = zero; 001 bne: !zero.
    - 100 blt: lt; 101 bge: !lt; 110 bltu: ltu; 111 bgeu: !ltu.
    - funct3 010 or 011: DECODE goes to TRAP instead of BRANCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Goes to ALUWB.
  - JALR1: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ResultSrc=10, PCWrite=1. The datapath clears bit 0 of the target. Goes to JALR2.
  - JALR2: ALUSrcA=01, ALUSrcB=10, ALUOp=00. Goes to ALUWB.
  - LUI: ALUSrcA=11, ALUSrcB=01, ALUOp=00. Goes to ALUWB.
  - AUIPC: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Goes to ALUWB.
  - TRAP: illegal set to 1; all enables 0; holds until rst.
- instret increments by 1 on the clock edge leaving a final state:
  - MEMWB, ALUWB, BRANCH, or MEMWRITE with mem_ready=1.
  - Wraps modulo 2^CNT_W. No increment on entering TRAP.
- Latencies from FETCH entry, with mem_ready=1:
  - branch 3 cycles; store 4 cycles.
  - R, I, LUI, AUIPC and JAL 4 cycles; load 5 cycles; JALR 5 cycles.
- Each cycle with mem_ready=0 adds one cycle in FETCH, MEMREAD or MEMWRITE.
- rst asserted in any state, including mid-stall or in TRAP, takes effect at the next edge; rst has priority.

Test Plan:
- addi x1,x0,5 (0x00500093), mem_ready=1 -> states FETCH, DECODE, EXECUTEI, ALUWB; ImmSrc=000; RegWrite=1 only in ALUWB; instret 0 to 1.
- sw x1,4(x2) (0x00112223), mem_ready low 3 cycles in MEMWRITE -> ImmSrc=001; MemWrite high 4 cycles; RegWrite never 1; instret increments once, on the ready cycle.
- beq x0,x0,8 (0x00000463) with zero=1 -> ImmSrc=010; PCWrite=1 in BRANCH. bne (0x00001463) with zero=1 -> PCWrite=0 in BRANCH. Both return to FETCH.
- jal x1,16 (0x010000EF) -> ImmSrc=100; PCWrite in FETCH and JAL; RegWrite in ALUWB.
- lw then jalr -> lw gives MEMREAD then MEMWB with ResultSrc=01; jalr passes through JALR1 and JALR2; each takes 5 cycles.
- Illegal instruction:
  - 0x00000000 -> TRAP; illegal=1; no enables for 10 cycles; instret unchanged.
  - Assert rst mid MEMWRITE stall -> next cycle in FETCH, MemWrite=0, illegal=0, instret=0.
